// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and constants for the UDP transmit arbiter.
// Package udp_pkg: FSM state encoding, header sizes, default payload limit.
package udp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_CHECK,
        S_START,
        S_RUN,
        S_DONE
    } state_e;

    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;
    localparam int DEF_MAX_LEN = 1472;

    function automatic logic len_bad(input logic [15:0] len,
                                     input int max_len);
        return (len == 16'd0) || (int'(len) > max_len);
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Handshake and parameter bus between the arbiter and the UDP sender.
// master = arbiter side, slave = sender side.
interface udp_tx_arbiter_if;

    logic [31:0] o_tx_dst_ip;
    logic [15:0] o_tx_dst_port;
    logic [15:0] o_tx_src_port;
    logic [15:0] o_tx_len;
    logic [7:0]  o_tx_data;
    logic        o_tx_enable;
    logic        i_tx_rd;
    logic        i_tx_ready;

    modport master (
        output o_tx_dst_ip, o_tx_dst_port, o_tx_src_port, o_tx_len,
        output o_tx_data, o_tx_enable,
        input  i_tx_rd, i_tx_ready
    );

    modport slave (
        input  o_tx_dst_ip, o_tx_dst_port, o_tx_src_port, o_tx_len,
        input  o_tx_data, o_tx_enable,
        output i_tx_rd, i_tx_ready
    );

endinterface

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// NCH-wide round-robin arbiter with one-hot grant.
// The priority pointer advances past the winner only when en is high.
module rr_arbiter
    import udp_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           en,
    output logic [NCH-1:0] gnt
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = PW'((int'(ptr_q) + i) % NCH);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = PW'((int'(idx) + 1) % NCH);
            end
        end
        if (!en) ptr_d = ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Multi-channel front end that serialises packet requests onto one UDP sender.
// Define UDP_ARB_TIMEOUT_EN to enable the START/RUN watchdog (o_timeout).
module udp_tx_arbiter
    import udp_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    i_req,
    output logic [NCH-1:0]    o_gnt,
    output logic [NCH-1:0]    o_done,
    output logic              o_drop,
    input  logic [NCH*32-1:0] i_ch_dst_ip,
    input  logic [NCH*16-1:0] i_ch_dst_port,
    input  logic [NCH*16-1:0] i_ch_src_port,
    input  logic [NCH*16-1:0] i_ch_len,
    input  logic [NCH*8-1:0]  i_ch_data,
    output logic [NCH-1:0]    o_ch_rd,
    udp_tx_arbiter_if.master  tx,
    output logic              o_busy,
    output logic              o_timeout
);

    state_e         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [NCH-1:0] done_q, done_d;
    logic           drop_q, drop_d;
    logic           en_q, en_d;
    logic [31:0]    ip_q, ip_d;
    logic [15:0]    dp_q, dp_d;
    logic [15:0]    sp_q, sp_d;
    logic [15:0]    len_q, len_d;

    logic           arb_en;
    logic [NCH-1:0] arb_gnt;
    logic [31:0]    sel_ip;
    logic [15:0]    sel_dp, sel_sp, sel_len;
    logic [7:0]     tx_data;

`ifdef UDP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`else
    logic unused_to;
    assign unused_to = (TIMEOUT_CYC > 0);
`endif

    rr_arbiter #(.NCH(NCH)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (i_req),
        .en  (arb_en),
        .gnt (arb_gnt)
    );

    always_comb begin
        sel_ip  = '0;
        sel_dp  = '0;
        sel_sp  = '0;
        sel_len = '0;
        tx_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (arb_gnt[k]) begin
                sel_ip  = i_ch_dst_ip[k*32 +: 32];
                sel_dp  = i_ch_dst_port[k*16 +: 16];
                sel_sp  = i_ch_src_port[k*16 +: 16];
                sel_len = i_ch_len[k*16 +: 16];
            end
            if (gnt_q[k]) tx_data = i_ch_data[k*8 +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        drop_d  = 1'b0;
        en_d    = en_q;
        ip_d    = ip_q;
        dp_d    = dp_q;
        sp_d    = sp_q;
        len_d   = len_q;
        arb_en  = 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|i_req && tx.i_tx_ready) state_d = S_ARB;
            end
            S_ARB: begin
                arb_en = 1'b1;
                // requester vanished since IDLE: nothing to send
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    ip_d    = sel_ip;
                    dp_d    = sel_dp;
                    sp_d    = sel_sp;
                    len_d   = sel_len;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (len_bad(len_q, MAX_LEN)) begin
                    done_d  = gnt_q;
                    drop_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    en_d    = 1'b1;
                    state_d = S_START;
`ifdef UDP_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_START: begin
                if (!tx.i_tx_ready) begin
                    en_d    = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (tx.i_tx_ready) begin
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef UDP_ARB_TIMEOUT_EN
        if (state_q == S_START || state_q == S_RUN) begin
            cnt_d = cnt_q + TW'(1);
            if (state_d != S_DONE && int'(cnt_d) >= TIMEOUT_CYC) begin
                to_d    = 1'b1;
                en_d    = 1'b0;
                done_d  = gnt_q;
                drop_d  = 1'b1;
                state_d = S_DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            drop_q  <= 1'b0;
            en_q    <= 1'b0;
            ip_q    <= '0;
            dp_q    <= '0;
            sp_q    <= '0;
            len_q   <= '0;
`ifdef UDP_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            en_q    <= en_d;
            ip_q    <= ip_d;
            dp_q    <= dp_d;
            sp_q    <= sp_d;
            len_q   <= len_d;
`ifdef UDP_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

`ifdef UDP_ARB_TIMEOUT_EN
    assign o_timeout = to_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_gnt            = gnt_q;
    assign o_done           = done_q;
    assign o_drop           = drop_q;
    assign o_busy           = (state_q != S_IDLE);
    assign o_ch_rd          = gnt_q & {NCH{tx.i_tx_rd}};
    assign tx.o_tx_dst_ip   = ip_q;
    assign tx.o_tx_dst_port = dp_q;
    assign tx.o_tx_src_port = sp_q;
    assign tx.o_tx_len      = len_q;
    assign tx.o_tx_data     = tx_data;
    assign tx.o_tx_enable   = en_q;

endmodule
